// File: rtl/keyboard_rx_fifo.sv
// ============================================================================
// Module   : keyboard_rx_fifo
// Purpose  : PS/2 keyboard receiver (deglitch, frame check, timeout) feeding
//            a scan-code FIFO. Optional macro: KEYBOARD_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyboard_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          keyboard_clk,
    input  logic                          keyboard_data,
    input  logic                          read,
    input  logic                          clear_errors,
    output logic                          scan_ready,
    output logic [7:0]                    scan_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_error
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_to_w-1:0]  c_to_one  = c_to_w'(1);
    localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    logic                  r_kclk_meta, r_kclk_sync;
    logic                  r_kdat_meta, r_kdat_sync;
    logic [FILTER_LEN-1:0] r_filter;
    logic                  r_kclk_filt, r_kclk_filt_d;
    logic                  w_strobe;

    logic [1:0]            r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic [c_to_w-1:0]     r_to_cnt;
    logic                  r_frame_error;
`ifdef KEYBOARD_PARITY_CHECK_EN
    logic                  r_parity;
`endif
    logic                  w_frame_ok;
    logic                  w_push;

    logic [7:0]            r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic                  w_full, w_empty, w_pop, w_wr, w_ovf;

    // Synchronisers, clock deglitch filter and falling-edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_kclk_meta   <= 1'b1;
            r_kclk_sync   <= 1'b1;
            r_kdat_meta   <= 1'b1;
            r_kdat_sync   <= 1'b1;
            r_filter      <= '1;
            r_kclk_filt   <= 1'b1;
            r_kclk_filt_d <= 1'b1;
        end else begin
            r_kclk_meta   <= keyboard_clk;
            r_kclk_sync   <= r_kclk_meta;
            r_kdat_meta   <= keyboard_data;
            r_kdat_sync   <= r_kdat_meta;
            r_filter      <= {r_filter[FILTER_LEN-2:0], r_kclk_sync};
            if (&r_filter) begin
                r_kclk_filt <= 1'b1;
            end else if (~|r_filter) begin
                r_kclk_filt <= 1'b0;
            end
            r_kclk_filt_d <= r_kclk_filt;
        end
    end

    assign w_strobe = r_kclk_filt_d & ~r_kclk_filt;

`ifdef KEYBOARD_PARITY_CHECK_EN
    assign w_frame_ok = r_kdat_sync & (^{r_shift, r_parity});
`else
    assign w_frame_ok = r_kdat_sync;
`endif

    assign w_push = (r_state == c_st_stop) & w_strobe & w_frame_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_to_cnt      <= '0;
            r_frame_error <= 1'b0;
`ifdef KEYBOARD_PARITY_CHECK_EN
            r_parity      <= 1'b0;
`endif
        end else begin
            r_frame_error <= 1'b0;
            if (r_state == c_st_idle) begin
                r_to_cnt <= '0;
                if (w_strobe && !r_kdat_sync) begin
                    r_state   <= c_st_data;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_strobe) begin
                r_to_cnt <= '0;
                case (r_state)
                    c_st_data: begin
                        r_shift   <= {r_kdat_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_st_parity;
                        end
                    end
                    c_st_parity: begin
`ifdef KEYBOARD_PARITY_CHECK_EN
                        r_parity <= r_kdat_sync;
`endif
                        r_state  <= c_st_stop;
                    end
                    default: begin
                        r_frame_error <= ~w_frame_ok;
                        r_state       <= c_st_idle;
                    end
                endcase
            end else if (r_to_cnt == c_to_last) begin
                // Keyboard stalled mid-frame: abandon the partial byte
                r_frame_error <= 1'b1;
                r_state       <= c_st_idle;
                r_to_cnt      <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_to_one;
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_cnt_full);
    assign w_pop   = read & ~w_empty;
    // A pop in the same cycle frees the slot the push needs
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_ovf   = w_push & w_full & ~w_pop;

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - c_cnt_one;
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end else if (clear_errors) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign scan_ready  = ~w_empty;
    assign scan_code   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule

`default_nettype wire

// File: tb/tb_keyboard_rx_fifo.sv
// ============================================================================
// Module   : tb_keyboard_rx_fifo
// Purpose  : Self-checking bench for keyboard_rx_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keyboard_rx_fifo;

    localparam int FILTER_LEN     = 8;
    localparam int FIFO_DEPTH     = 16;
    localparam int TIMEOUT_CYCLES = 500;
    localparam int HALF           = 30;

`ifdef KEYBOARD_PARITY_CHECK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       keyboard_clk = 1'b1;
    logic       keyboard_data = 1'b1;
    logic       read = 1'b0;
    logic       clear_errors = 1'b0;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       frame_error;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         fe_seen  = 0;
    int         fe_exp   = 0;
    logic [7:0] q[$];
    logic       ovf_exp  = 1'b0;

    keyboard_rx_fifo #(
        .FILTER_LEN     (FILTER_LEN),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .keyboard_clk  (keyboard_clk),
        .keyboard_data (keyboard_data),
        .read          (read),
        .clear_errors  (clear_errors),
        .scan_ready    (scan_ready),
        .scan_code     (scan_code),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .frame_error   (frame_error)
    );

    always #5 clock = ~clock;

    // Every high cycle counts, so a stretched pulse shows up as extra errors
    always @(negedge clock) begin
        if (frame_error === 1'b1) fe_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: a bounded queue fed by the outcome of each frame
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_stop || (PAR_CHK && bad_par)) begin
            fe_exp++;
        end else if (q.size() >= FIFO_DEPTH) begin
            ovf_exp = 1'b1;
        end else begin
            q.push_back(b);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        logic        p;
        p = ~(^b) ^ bad_par;
        f = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clock) keyboard_data = f[i];
            repeat (HALF) @(negedge clock);
            if (i == glitch_bit) begin
                keyboard_clk = 1'b0;
                repeat (3) @(negedge clock);
                keyboard_clk = 1'b1;
                repeat (HALF) @(negedge clock);
            end
            keyboard_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            keyboard_clk = 1'b1;
        end
        @(negedge clock) keyboard_data = 1'b1;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic do_pop();
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++; if (scan_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", scan_ready); end
        n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_code got=%h want=00", scan_code); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        n_checks++; if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error got=%b want=0", frame_error); end
        reset = 1'b0;
        repeat (20) @(negedge clock);
    endtask

    task automatic test_single();
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        model_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (scan_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%b want=1", scan_ready); end
        n_checks++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL single_code got=%h want=1c", scan_code); end
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL single_count got=%0d want=1", fifo_count); end
        do_pop();
        void'(q.pop_front());
        n_checks++; if (scan_ready !== 1'b0) begin n_fail++; $display("FAIL pop_ready got=%b want=0", scan_ready); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL pop_count got=%0d want=0", fifo_count); end
        n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL pop_code got=%h want=00", scan_code); end
        // Popping an empty FIFO must be harmless
        do_pop();
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL empty_pop_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b;
        for (int i = 1; i <= 17; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, 11, -1);
            model_frame(8'(i), 1'b0, 1'b0);
        end
        n_checks++; if (fifo_count !== 5'(q.size())) begin n_fail++; $display("FAIL ovf_count got=%0d want=%0d", fifo_count, q.size()); end
        n_checks++; if (overflow !== ovf_exp) begin n_fail++; $display("FAIL ovf_flag got=%b want=%b", overflow, ovf_exp); end
        for (int i = 0; i < 16; i++) begin
            exp_b = q.pop_front();
            n_checks++; if (scan_code !== exp_b) begin n_fail++; $display("FAIL ovf_order[%0d] got=%h want=%h", i, scan_code, exp_b); end
            do_pop();
        end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL ovf_drain_count got=%0d want=0", fifo_count); end
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        ovf_exp = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    endtask

    task automatic test_parity();
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        model_frame(8'h1C, 1'b1, 1'b0);
        n_checks++; if (fe_seen !== fe_exp) begin n_fail++; $display("FAIL parity_fe got=%0d want=%0d", fe_seen, fe_exp); end
        n_checks++; if (fifo_count !== 5'(q.size())) begin n_fail++; $display("FAIL parity_count got=%0d want=%0d", fifo_count, q.size()); end
        if (q.size() != 0) begin
            n_checks++; if (scan_code !== q[0]) begin n_fail++; $display("FAIL parity_code got=%h want=%h", scan_code, q[0]); end
            do_pop();
            void'(q.pop_front());
        end
    endtask

    task automatic test_stop_bit();
        send_frame(8'h3B, 1'b0, 1'b1, 11, -1);
        model_frame(8'h3B, 1'b0, 1'b1);
        n_checks++; if (fe_seen !== fe_exp) begin n_fail++; $display("FAIL stop_fe got=%0d want=%0d", fe_seen, fe_exp); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL stop_count got=%0d want=0", fifo_count); end
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        model_frame(8'hF0, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'hF0) begin n_fail++; $display("FAIL stop_next_code got=%h want=f0", scan_code); end
        do_pop();
        void'(q.pop_front());
    endtask

    task automatic test_timeout();
        send_frame(8'hA5, 1'b0, 1'b0, 5, -1);
        repeat (TIMEOUT_CYCLES + 50) @(negedge clock);
        fe_exp++;
        n_checks++; if (fe_seen !== fe_exp) begin n_fail++; $display("FAIL timeout_fe got=%0d want=%0d", fe_seen, fe_exp); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL timeout_count got=%0d want=0", fifo_count); end
        send_frame(8'h76, 1'b0, 1'b0, 11, -1);
        model_frame(8'h76, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h76) begin n_fail++; $display("FAIL timeout_next_code got=%h want=76", scan_code); end
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL timeout_next_count got=%0d want=1", fifo_count); end
        do_pop();
        void'(q.pop_front());
    endtask

    task automatic test_glitch_and_reset();
        send_frame(8'h5A, 1'b0, 1'b0, 11, 4);
        model_frame(8'h5A, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h5A) begin n_fail++; $display("FAIL glitch_code got=%h want=5a", scan_code); end
        n_checks++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL glitch_count got=%0d want=1", fifo_count); end
        n_checks++; if (fe_seen !== fe_exp) begin n_fail++; $display("FAIL glitch_fe got=%0d want=%0d", fe_seen, fe_exp); end
        // Leave 0x5A buffered so the reset visibly empties the FIFO
        send_frame(8'hC3, 1'b0, 1'b0, 4, -1);
        reset = 1'b1;
        #1;
        q.delete();
        ovf_exp = 1'b0;
        n_checks++; if (scan_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got=%b want=0", scan_ready); end
        n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL midreset_count got=%0d want=0", fifo_count); end
        n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL midreset_code got=%h want=00", scan_code); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (TIMEOUT_CYCLES + 20) @(negedge clock);
        n_checks++; if (fe_seen !== fe_exp) begin n_fail++; $display("FAIL midreset_fe got=%0d want=%0d", fe_seen, fe_exp); end
        send_frame(8'h29, 1'b0, 1'b0, 11, -1);
        model_frame(8'h29, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h29) begin n_fail++; $display("FAIL midreset_next_code got=%h want=29", scan_code); end
        do_pop();
        void'(q.pop_front());
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] exp_b;
        int         kind;
        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            kind = $urandom_range(0, 3);
            send_frame(b, kind == 2, kind == 3, 11, ($urandom_range(0, 3) == 0) ? 6 : -1);
            model_frame(b, kind == 2, kind == 3);
            if ($urandom_range(0, 1) == 1 && q.size() != 0) begin
                exp_b = q.pop_front();
                n_checks++; if (scan_code !== exp_b) begin n_fail++; $display("FAIL rand_code[%0d] got=%h want=%h", i, scan_code, exp_b); end
                do_pop();
            end
        end
        n_checks++; if (fe_seen !== fe_exp) begin n_fail++; $display("FAIL rand_fe got=%0d want=%0d", fe_seen, fe_exp); end
        n_checks++; if (fifo_count !== 5'(q.size())) begin n_fail++; $display("FAIL rand_count got=%0d want=%0d", fifo_count, q.size()); end
        while (q.size() != 0) begin
            exp_b = q.pop_front();
            n_checks++; if (scan_code !== exp_b) begin n_fail++; $display("FAIL rand_drain got=%h want=%h", scan_code, exp_b); end
            do_pop();
        end
        n_checks++; if (scan_ready !== 1'b0) begin n_fail++; $display("FAIL rand_empty got=%b want=0", scan_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_parity();
        test_stop_bit();
        test_timeout();
        test_glitch_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
